// File: rtl/maxpool2x2_window_gen.sv
// Raster-to-window feeder for the 2x2 max-pool core: builds non-overlapping
// stride-2 windows from a row-major pixel stream using one line buffer.
module maxpool2x2_window_gen #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned IMG_W  = 24,
  parameter int unsigned IMG_H  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sof,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] din,
  output logic              valid_out,
  output logic [DATA_W-1:0] p00,
  output logic [DATA_W-1:0] p01,
  output logic [DATA_W-1:0] p10,
  output logic [DATA_W-1:0] p11,
  output logic              frame_done
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]  col_q, col_d, cur_col, col_m1;
  logic [ROW_W-1:0]  row_q, row_d, cur_row;
  logic [DATA_W-1:0] held_q, held_d;
  logic              valid_out_q, valid_out_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] p00_q, p00_d, p01_q, p01_d, p10_q, p10_d, p11_q, p11_d;
  logic              lb_we;
  logic [DATA_W-1:0] linebuf_q [IMG_W];

  // sof forces the current position to (0,0) before the pixel is placed
  always_comb begin
    cur_col      = sof ? '0 : col_q;
    cur_row      = sof ? '0 : row_q;
    col_m1       = cur_col - COL_W'(1);
    col_d        = cur_col;
    row_d        = cur_row;
    held_d       = held_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    p00_d        = p00_q;
    p01_d        = p01_q;
    p10_d        = p10_q;
    p11_d        = p11_q;
    lb_we        = 1'b0;

    if (valid_in) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
      end
      frame_done_d = (cur_col == COL_LAST) && (cur_row == ROW_LAST);

      if (!cur_row[0]) begin
        lb_we = 1'b1;
      end else if (!cur_col[0]) begin
        held_d = din;
      end else begin
        valid_out_d = 1'b1;
        p00_d       = linebuf_q[col_m1];
        p01_d       = linebuf_q[cur_col];
        p10_d       = held_q;
        p11_d       = din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      held_q       <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      p00_q        <= '0;
      p01_q        <= '0;
      p10_q        <= '0;
      p11_q        <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      held_q       <= held_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
      p00_q        <= p00_d;
      p01_q        <= p01_d;
      p10_q        <= p10_d;
      p11_q        <= p11_d;
    end
  end

  // Line buffer holds the previous even row; contents need no reset
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_q[cur_col] <= din;
    end
  end

  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;
  assign p00        = p00_q;
  assign p01        = p01_q;
  assign p10        = p10_q;
  assign p11        = p11_q;

endmodule

// File: tb/tb_maxpool2x2_window_gen.sv
// Directed, table-driven bench for maxpool2x2_window_gen on 4x4, 5x5 and 2x2 frames.
module tb_maxpool2x2_window_gen;

  localparam int unsigned DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sof = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] din = '0;

  logic          vo_a, vo_b, vo_c, fd_a, fd_b, fd_c;
  logic [DW-1:0] a00, a01, a10, a11, b00, b01, b10, b11, c00, c01, c10, c11;

  always #5 clk = ~clk;

  maxpool2x2_window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_a (
    .clk(clk), .rst_n(rst_n), .sof(sof), .valid_in(valid_in), .din(din),
    .valid_out(vo_a), .p00(a00), .p01(a01), .p10(a10), .p11(a11), .frame_done(fd_a));
  maxpool2x2_window_gen #(.DATA_W(DW), .IMG_W(5), .IMG_H(5)) u_b (
    .clk(clk), .rst_n(rst_n), .sof(sof), .valid_in(valid_in), .din(din),
    .valid_out(vo_b), .p00(b00), .p01(b01), .p10(b10), .p11(b11), .frame_done(fd_b));
  maxpool2x2_window_gen #(.DATA_W(DW), .IMG_W(2), .IMG_H(2)) u_c (
    .clk(clk), .rst_n(rst_n), .sof(sof), .valid_in(valid_in), .din(din),
    .valid_out(vo_c), .p00(c00), .p01(c01), .p10(c10), .p11(c11), .frame_done(fd_c));

  typedef struct {
    int p00; int p01; int p10; int p11; int after;
  } win_t;

  typedef struct {
    int inst; int w; int h; int base; bit gaps; int first; int nwin; int fd_val;
  } scen_t;

  int   tests = 0;
  int   fails = 0;
  int   sel = 0;
  win_t exp_w [17];
  win_t q [$];
  int   fd_q [$];
  int   spurious = 0;
  int   last_acc = 0;
  bit   acc_edge = 1'b0;

  logic              m_vo, m_fd;
  logic signed [DW-1:0] m00, m01, m10, m11;

  always_comb begin
    case (sel)
      1:       begin m_vo = vo_b; m_fd = fd_b; m00 = b00; m01 = b01; m10 = b10; m11 = b11; end
      2:       begin m_vo = vo_c; m_fd = fd_c; m00 = c00; m01 = c01; m10 = c10; m11 = c11; end
      default: begin m_vo = vo_a; m_fd = fd_a; m00 = a00; m01 = a01; m10 = a10; m11 = a11; end
    endcase
  end

  // Remember which pixel the most recent edge accepted
  always @(posedge clk) begin
    acc_edge = valid_in;
    if (valid_in) last_acc = int'($signed(din));
  end

  always @(negedge clk) begin
    if (m_vo) begin
      q.push_back('{int'(m00), int'(m01), int'(m10), int'(m11), last_acc});
      if (!acc_edge) spurious++;
    end
    if (m_fd) fd_q.push_back(last_acc);
  end

  task automatic cmp(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q.delete();
    fd_q.delete();
    spurious = 0;
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    sof      = 1'b0;
    rst_n    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    clear_mon();
  endtask

  task automatic send_px(input int v, input bit s);
    din      = DW'(v);
    valid_in = 1'b1;
    sof      = s;
    step();
    valid_in = 1'b0;
    sof      = 1'b0;
  endtask

  task automatic run_frame(input int n, input int base, input bit gaps, input bit sof_first);
    for (int i = 0; i < n; i++) begin
      send_px(base + i, sof_first && (i == 0));
      if (gaps) repeat ($urandom_range(1, 3)) step();
    end
  endtask

  task automatic check_wins(input string tag, input int qoff, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      tests++;
      if (qoff + k >= q.size()) begin
        fails++;
        $display("FAIL %s win%0d: got none, expected (%0d,%0d,%0d,%0d)@%0d", tag, k,
                 exp_w[first+k].p00, exp_w[first+k].p01, exp_w[first+k].p10,
                 exp_w[first+k].p11, exp_w[first+k].after);
      end else if (q[qoff+k] != exp_w[first+k]) begin
        fails++;
        $display("FAIL %s win%0d: got (%0d,%0d,%0d,%0d)@%0d, expected (%0d,%0d,%0d,%0d)@%0d",
                 tag, k, q[qoff+k].p00, q[qoff+k].p01, q[qoff+k].p10, q[qoff+k].p11,
                 q[qoff+k].after, exp_w[first+k].p00, exp_w[first+k].p01,
                 exp_w[first+k].p10, exp_w[first+k].p11, exp_w[first+k].after);
      end
    end
  endtask

  task automatic check_fd(input string tag, input int n, input int v0);
    cmp({tag, " frame_done count"}, fd_q.size(), n);
    cmp({tag, " frame_done after"}, (fd_q.size() > 0) ? fd_q[0] : -999, v0);
  endtask

  scen_t sc [3];

  initial begin
    exp_w[0]  = '{0, 1, 4, 5, 5};         exp_w[1]  = '{2, 3, 6, 7, 7};
    exp_w[2]  = '{8, 9, 12, 13, 13};      exp_w[3]  = '{10, 11, 14, 15, 15};
    exp_w[4]  = '{0, 1, 5, 6, 6};         exp_w[5]  = '{2, 3, 7, 8, 8};
    exp_w[6]  = '{10, 11, 15, 16, 16};    exp_w[7]  = '{12, 13, 17, 18, 18};
    exp_w[8]  = '{100, 101, 104, 105, 105}; exp_w[9]  = '{102, 103, 106, 107, 107};
    exp_w[10] = '{108, 109, 112, 113, 113}; exp_w[11] = '{110, 111, 114, 115, 115};
    exp_w[12] = '{200, 201, 204, 205, 205}; exp_w[13] = '{202, 203, 206, 207, 207};
    exp_w[14] = '{208, 209, 212, 213, 213}; exp_w[15] = '{210, 211, 214, 215, 215};
    exp_w[16] = '{-1, -8388608, 8388607, 0, 0};

    sc[0] = '{0, 4, 4, 0, 1'b0, 0, 4, 15};
    sc[1] = '{0, 4, 4, 0, 1'b1, 0, 4, 15};
    sc[2] = '{1, 5, 5, 0, 1'b0, 4, 4, 24};

    // Reset state
    #1;
    cmp("reset valid_out", int'(m_vo), 0);
    cmp("reset frame_done", int'(m_fd), 0);
    cmp("reset p00", int'(m00), 0);
    cmp("reset p11", int'(m11), 0);

    foreach (sc[i]) begin
      string tag;
      tag = $sformatf("scen%0d", i);
      sel = sc[i].inst;
      do_reset();
      run_frame(sc[i].w * sc[i].h, sc[i].base, sc[i].gaps, 1'b0);
      repeat (3) step();
      cmp({tag, " window count"}, q.size(), sc[i].nwin);
      check_wins(tag, 0, sc[i].first, sc[i].nwin);
      cmp({tag, " gap pulses"}, spurious, 0);
      check_fd(tag, 1, sc[i].fd_val);
    end

    // Signed extremes through a 2x2 frame
    sel = 2;
    do_reset();
    send_px(-1, 1'b0);
    send_px(-8388608, 1'b0);
    send_px(8388607, 1'b0);
    send_px(0, 1'b0);
    repeat (3) step();
    cmp("signed window count", q.size(), 1);
    check_wins("signed", 0, 16, 1);
    check_fd("signed", 1, 0);

    // Async reset mid-frame, then a clean frame
    sel = 0;
    do_reset();
    run_frame(7, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    cmp("midrst valid_out", int'(m_vo), 0);
    cmp("midrst p00", int'(m00), 0);
    cmp("midrst p01", int'(m01), 0);
    cmp("midrst p10", int'(m10), 0);
    cmp("midrst p11", int'(m11), 0);
    cmp("midrst frame_done", int'(m_fd), 0);
    step();
    rst_n = 1'b1;
    step();
    clear_mon();
    run_frame(16, 0, 1'b0, 1'b0);
    repeat (3) step();
    cmp("midrst window count", q.size(), 4);
    check_wins("midrst", 0, 0, 4);

    // Back-to-back frames with no bubble
    do_reset();
    run_frame(16, 0, 1'b0, 1'b0);
    run_frame(16, 100, 1'b0, 1'b0);
    repeat (3) step();
    cmp("b2b window count", q.size(), 8);
    check_wins("b2b f0", 0, 0, 4);
    check_wins("b2b f1", 4, 8, 4);
    cmp("b2b frame_done count", fd_q.size(), 2);
    cmp("b2b frame_done 2nd", (fd_q.size() > 1) ? fd_q[1] : -999, 115);

    // sof after a 3-pixel partial frame
    do_reset();
    run_frame(3, 0, 1'b0, 1'b0);
    run_frame(16, 100, 1'b0, 1'b1);
    repeat (3) step();
    cmp("sof window count", q.size(), 4);
    check_wins("sof", 0, 8, 4);
    check_fd("sof", 1, 115);

    // sof coinciding with a window-forming pixel suppresses that window
    do_reset();
    run_frame(5, 0, 1'b0, 1'b0);
    run_frame(16, 200, 1'b0, 1'b1);
    repeat (3) step();
    cmp("sofwin window count", q.size(), 4);
    check_wins("sofwin", 0, 12, 4);
    check_fd("sofwin", 1, 215);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/maxpool2x2_window_gen.md
Name: maxpool2x2_window_gen

Overview:
- Upstream feeder for the 2x2 max-pool core.
- Accepts a raster-order stream of signed feature-map pixels (one per valid_in cycle, row-major, one channel) from the conv/ReLU stage.
- Assembles non-overlapping 2x2, stride-2 windows using one line buffer and a held-pixel register.
- Presents each window as p00/p01/p10/p11 with a single-cycle valid_out, wired directly to the pool core's valid_in and p* inputs.

Parameters:
- DATA_W, 24, pixel width (signed, two's complement).
- IMG_W, 24, pixels per input row; must be at least 2.
- IMG_H, 24, rows per input frame; must be at least 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- sof  input  1  synchronous frame restart: clears row/col counters; same-cycle valid_in pixel is taken as pixel (0,0).
- valid_in  input  1  din holds a valid pixel this cycle.
- din  input  DATA_W  signed pixel.
- valid_out  output  1  window valid, one-cycle pulse per window.
- p00  output  DATA_W  window top-left (even row, even col).
- p01  output  DATA_W  window top-right.
- p10  output  DATA_W  window bottom-left (odd row, even col).
- p11  output  DATA_W  window bottom-right.
- frame_done  output  1  one-cycle pulse, registered, asserted the cycle after the last pixel of the frame (row IMG_H-1, col IMG_W-1) is accepted.

Behaviour:
- Reset: all outputs 0; col/row counters 0; held register 0. Line-buffer contents need no reset.
- Reset mid-frame discards the partial frame. The next accepted pixel is (0,0).
- Counters:
  - col runs 0..IMG_W-1 and advances only on valid_in.
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - At row=IMG_H-1 and col=IMG_W-1, both wrap to 0.
  - Widths are $clog2 of IMG_W and of IMG_H, minimum 1.
- No backpressure. valid_in may have arbitrary gaps, and all state holds when valid_in=0.
- Even row (row[0]=0): every accepted pixel is written to linebuf[col]. No output.
- Odd row, even col: the pixel is stored in the held register. No output.
- Odd row, odd col:
  - Next cycle: valid_out=1, p00=linebuf[col-1], p01=linebuf[col], p10=held, p11=din.
  - Latency is exactly 1 clock from the accepting edge.
- Line buffer: IMG_W x DATA_W registers or distributed RAM. The read is combinational from the previous row's writes, so there is no read/write hazard on the same address.
- p00..p11 hold their last values when valid_out=0.
- Odd dimensions (floor semantics):
  - If IMG_W is odd, column IMG_W-1 is accepted and counted but never forms a window.
  - If IMG_H is odd, row IMG_H-1 is written to the buffer but never emits.
  - Windows per frame = floor(IMG_W/2) * floor(IMG_H/2).
- sof priority: sof overrides the counter state. If sof=1 and valid_in=1, the pixel is at (0,0) and counters move to (0,1), or to (1,0) when IMG_W=1 (excluded by the IMG_W parameter constraint).
- sof on a window-forming cycle: a window completing the same cycle sof is asserted is not emitted.
- Back-to-back frames: the first pixel of frame N+1 may arrive the cycle immediately after the last pixel of frame N, with no bubble required.
- Data is passed through unmodified. No arithmetic and no sign extension.

Test Plan:
- 4x4 frame, din=0..15 raster, continuous valid → 4 valid_out pulses:
  - (p00,p01,p10,p11) = (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15).
  - Each pulse one cycle after pixels 5, 7, 13, 15 respectively.
  - frame_done the cycle after pixel 15.
- Same 4x4 stream with valid_in=0 for 1-3 random cycles between pixels → identical window values and order; valid_out is never asserted during gaps.
- IMG_W=5, IMG_H=5, din=0..24 → 4 windows: (0,1,5,6), (2,3,7,8), (10,11,15,16), (12,13,17,18). frame_done after pixel 24.
- Signed data with DATA_W=24 on a 2x2 frame, din=-1,-8388608,8388607,0 → one window with p00=-1, p01=-8388608, p10=8388607, p11=0, bit-exact.
- rst_n pulsed low after pixel 6 of a 4x4 frame:
  - Outputs are 0 immediately.
  - A fresh 0..15 frame then yields exactly the 4 windows of scenario 1.
  - No stale window is emitted.
- Two consecutive 4x4 frames with no gap, second frame 100..115, plus a mid-frame sof test:
  - The second frame yields (100,101,104,105) ... (110,111,114,115).
  - sof asserted with pixel 100 after a 3-pixel partial frame realigns output to these same windows.
